fetch_queue: RTL and testbench

Instruction fetch queue between the frontend and the decoder: receives up to `INSTR_PER_FETCH` `fetch_entry_t` records per cycle, compacts the valid ones, and delivers them to decode one per cycle in program order. The queue absorbs frontend/decode rate mismatch. It is the receiving end of the frontend's fetch-entry stream, and its storage is discarded on a pipeline flush.

---
 rtl/fetch_queue.sv | 192 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch queue sitting between the frontend and the decoder.
// Each fetch beat carries up to NR_LANES fetch_entry_t records; the valid
// lanes are compacted into a circular buffer and handed to decode one per
// cycle in program order. A flush discards everything that is queued.
//
// Optional feature macro: CONFIG_IFQ_BYPASS_EN
//   When defined, an empty queue forwards the lowest valid lane of an
//   incoming beat straight onto the decode outputs in the same cycle.
//   When undefined, decode outputs come purely from registers.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset (clears pointers/count)
//   flush_i          discard all queued entries; wins over push and pop
//   fetch_valid_i    a fetch beat is present on fetch_entries_i
//   fetch_entries_i  NR_LANES entries, lane 0 oldest, each with .valid
//   fetch_ready_o    room for a whole beat (from registered count only)
//   decode_valid_o   decode_entry_o holds the oldest entry
//   decode_entry_o   head entry, all zeros when nothing to deliver
//   decode_ready_i   decoder takes the head this cycle
//   count_o          number of stored entries
// ---------------------------------------------------------------------------

package fetch_queue_pkg;

  localparam int IFQ_DEPTH       = 8;
  localparam int INSTR_PER_FETCH = 2;

  typedef struct packed {
    logic        valid;
    logic [3:0]  cause;
    logic [31:0] tval;
  } exception_t;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
  } branchpredict_t;

  typedef struct packed {
    logic           valid;
    logic [31:0]    address;
    logic [31:0]    instruction;
    branchpredict_t predict;
    exception_t     ex;
  } fetch_entry_t;

endpackage

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH    = IFQ_DEPTH,
  parameter int NR_LANES = INSTR_PER_FETCH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         fetch_valid_i,
  input  fetch_entry_t [NR_LANES-1:0]  fetch_entries_i,
  output logic                         fetch_ready_o,
  output logic                         decode_valid_o,
  output fetch_entry_t                 decode_entry_o,
  input  logic                         decode_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  // DEPTH must be a power of two so the pointers wrap for free.
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int LW  = $clog2(NR_LANES+1);
  localparam int LIW = (NR_LANES > 1) ? $clog2(NR_LANES) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [NR_LANES-1:0] w_laneWrite;
  logic [PW-1:0] w_laneOffset [NR_LANES];
  logic [LW-1:0] w_nWrite;

  // Ready looks only at the registered count, so a pop in the same cycle
  // never opens room for a push.
  assign w_empty       = (r_count == '0);
  assign fetch_ready_o = (r_count <= CW'(DEPTH - NR_LANES));
  assign w_push        = fetch_valid_i & fetch_ready_o;
  assign count_o       = r_count;

  // Storage pop: only a stored head can be consumed; a bypassed lane is
  // never in storage, so it does not move the read pointer.
  assign w_pop = ~w_empty & decode_ready_i;

`ifdef CONFIG_IFQ_BYPASS_EN
  logic           w_anyLaneValid;
  logic [LIW-1:0] w_lowestLane;
  logic           w_bypass;
  logic           w_bypassTake;

  // Find the oldest valid lane of the incoming beat; scanning from the
  // top down leaves the lowest index in place.
  always_comb begin
    w_anyLaneValid = 1'b0;
    w_lowestLane   = '0;
    for (int l = NR_LANES-1; l >= 0; l--) begin
      if (fetch_entries_i[l].valid) begin
        w_anyLaneValid = 1'b1;
        w_lowestLane   = LIW'(l);
      end
    end
  end

  assign w_bypass     = w_empty & fetch_valid_i & ~flush_i & w_anyLaneValid;
  assign w_bypassTake = w_bypass & decode_ready_i;
`endif

  // Compaction: each written lane lands at wrPtr plus the number of
  // written lanes below it. A lane consumed through the bypass is skipped
  // so the remaining lanes close up behind it.
  always_comb begin
    logic [LW-1:0] acc;
    acc         = '0;
    w_laneWrite = '0;
    for (int l = 0; l < NR_LANES; l++) begin
      w_laneOffset[l] = PW'(acc);
      if (w_push && fetch_entries_i[l].valid) begin
        w_laneWrite[l] = 1'b1;
`ifdef CONFIG_IFQ_BYPASS_EN
        if (w_bypassTake && (LIW'(l) == w_lowestLane)) begin
          w_laneWrite[l] = 1'b0;
        end
`endif
      end
      if (w_laneWrite[l]) begin
        acc = acc + LW'(1);
      end
    end
    w_nWrite = acc;
  end

  // Pointer and occupancy bookkeeping. Flush shares the reset path, which
  // also drops any same-cycle push and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_wrPtr <= r_wrPtr + PW'(w_nWrite);
      r_count <= r_count + CW'(w_nWrite) - CW'(w_pop);
    end
  end

  // Entry storage has no reset; a beat that wraps past DEPTH-1 writes both
  // ends of the buffer in the same cycle through the modulo addition.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int l = 0; l < NR_LANES; l++) begin
        if (w_laneWrite[l]) begin
          r_mem[r_wrPtr + w_laneOffset[l]] <= fetch_entries_i[l];
        end
      end
    end
  end

  // Decode side: stored head when present, otherwise the bypass lane if
  // that feature is built in, otherwise zeros so .valid tracks the valid.
  always_comb begin
    decode_entry_o = '0;
    decode_valid_o = ~w_empty;
    if (!w_empty) begin
      decode_entry_o = r_mem[r_rdPtr];
    end
`ifdef CONFIG_IFQ_BYPASS_EN
    else if (w_bypass) begin
      decode_entry_o = fetch_entries_i[w_lowestLane];
      decode_valid_o = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed bench for fetch_queue with DEPTH=8, NR_LANES=2. Each scenario
// task drives its own vectors and compares outputs against hand-derived
// values. Build with CONFIG_IFQ_BYPASS_EN to add the bypass scenario.
// ---------------------------------------------------------------------------

module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic                      clk;
  logic                      rst_i;
  logic                      flush_i;
  logic                      fetch_valid_i;
  fetch_entry_t [1:0]        fetch_entries_i;
  logic                      fetch_ready_o;
  logic                      decode_valid_o;
  fetch_entry_t              decode_entry_o;
  logic                      decode_ready_i;
  logic [3:0]                count_o;

  int testsRun;
  int testsFailed;

  fetch_queue #(
    .DEPTH    (8),
    .NR_LANES (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .fetch_valid_i   (fetch_valid_i),
    .fetch_entries_i (fetch_entries_i),
    .fetch_ready_o   (fetch_ready_o),
    .decode_valid_o  (decode_valid_o),
    .decode_entry_o  (decode_entry_o),
    .decode_ready_i  (decode_ready_i),
    .count_o         (count_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Build a recognisable valid entry from a small id.
  function automatic fetch_entry_t mk(input logic [7:0] id);
    fetch_entry_t e;
    e                = '0;
    e.valid          = 1'b1;
    e.address        = {22'h200000, id, 2'b00};
    e.instruction    = {8'h13, 16'h0000, id};
    e.predict.valid  = id[0];
    e.predict.taken  = id[1];
    e.predict.target = {24'h400000, id};
    return e;
  endfunction

  // Step past the next rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one fetch beat (or idle when valid is 0).
  task automatic applyStimulus(input fetch_entry_t l0, input fetch_entry_t l1,
                               input logic valid);
    fetch_entries_i[0] = l0;
    fetch_entries_i[1] = l1;
    fetch_valid_i      = valid;
  endtask

  task automatic doReset();
    rst_i          = 1'b1;
    flush_i        = 1'b0;
    decode_ready_i = 1'b0;
    applyStimulus('0, '0, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // Reset values of every output.
  task automatic test_reset();
    doReset();
    testsRun++;
    if (fetch_ready_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: got %b expected 1", fetch_ready_o);
    end
    testsRun++;
    if (decode_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", decode_valid_o);
    end
    testsRun++;
    if (decode_entry_o !== fetch_entry_t'(0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_entry: got %h expected 0", decode_entry_o);
    end
    testsRun++;
    if (count_o !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_count: got %0d expected 0", count_o);
    end
  endtask

  // Two-entry beat right after reset, decoder always ready.
  task automatic test_ordering();
    fetch_entry_t a, b;
    a = mk(8'h0A);
    b = mk(8'h0B);
    doReset();
    decode_ready_i = 1'b1;
    applyStimulus(a, b, 1'b1);
    #1;
    testsRun++;
    if (decode_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL order_push_cycle_valid: got %b expected 0", decode_valid_o);
    end
    tick();
    applyStimulus('0, '0, 1'b0);
    testsRun++;
    if (decode_entry_o !== a || decode_valid_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL order_first: got %h expected %h", decode_entry_o, a);
    end
    testsRun++;
    if (count_o !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL order_count2: got %0d expected 2", count_o);
    end
    tick();
    testsRun++;
    if (decode_entry_o !== b || decode_valid_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL order_second: got %h expected %h", decode_entry_o, b);
    end
    testsRun++;
    if (count_o !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL order_count1: got %0d expected 1", count_o);
    end
    tick();
    testsRun++;
    if (count_o !== 4'd0 || decode_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL order_empty: got count %0d valid %b expected 0 0", count_o, decode_valid_o);
    end
    decode_ready_i = 1'b0;
  endtask

  // Invalid lane 0 must be squeezed out, keeping C, D, E in order.
  task automatic test_compaction();
    fetch_entry_t junk;
    fetch_entry_t exp[$];
    junk       = mk(8'hEE);
    junk.valid = 1'b0;
    decode_ready_i = 1'b0;
    applyStimulus(junk, mk(8'h0C), 1'b1);
    tick();
    applyStimulus(mk(8'h0D), mk(8'h0E), 1'b1);
    tick();
    applyStimulus('0, '0, 1'b0);
    exp = '{mk(8'h0C), mk(8'h0D), mk(8'h0E)};
    testsRun++;
    if (count_o !== 4'd3) begin
      testsFailed++;
      $display("[TB] FAIL compact_count: got %0d expected 3", count_o);
    end
    decode_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (decode_entry_o !== exp[i] || decode_valid_o !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL compact_order%0d: got %h expected %h", i, decode_entry_o, exp[i]);
      end
      tick();
    end
    testsRun++;
    if (count_o !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL compact_drained: got %0d expected 0", count_o);
    end
    decode_ready_i = 1'b0;
  endtask

  // Fill, pop, wrap the write pointer across slot 7 -> 0, hit the full
  // boundary, then push and pop together at count DEPTH-NR_LANES.
  task automatic test_full_wrap();
    fetch_entry_t exp[$];
    doReset();
    decode_ready_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      applyStimulus(mk(8'(32 + 2*b)), mk(8'(33 + 2*b)), 1'b1);
      exp.push_back(mk(8'(32 + 2*b)));
      exp.push_back(mk(8'(33 + 2*b)));
      tick();
    end
    applyStimulus('0, '0, 1'b0);
    testsRun++;
    if (count_o !== 4'd6) begin
      testsFailed++;
      $display("[TB] FAIL full_count6: got %0d expected 6", count_o);
    end
    testsRun++;
    if (fetch_ready_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL full_ready_at6: got %b expected 1", fetch_ready_o);
    end
    decode_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      testsRun++;
      if (decode_entry_o !== exp[0]) begin
        testsFailed++;
        $display("[TB] FAIL full_pop%0d: got %h expected %h", i, decode_entry_o, exp[0]);
      end
      tick();
      void'(exp.pop_front());
    end
    decode_ready_i = 1'b0;
    applyStimulus(mk(8'h0F), mk(8'h10), 1'b1);
    tick();
    exp.push_back(mk(8'h0F));
    exp.push_back(mk(8'h10));
    applyStimulus('0, '0, 1'b0);
    decode_ready_i = 1'b1;
    tick();
    void'(exp.pop_front());
    decode_ready_i = 1'b0;
    applyStimulus(mk(8'h11), mk(8'h12), 1'b1);
    tick();
    exp.push_back(mk(8'h11));
    exp.push_back(mk(8'h12));
    applyStimulus('0, '0, 1'b0);
    testsRun++;
    if (count_o !== 4'd7) begin
      testsFailed++;
      $display("[TB] FAIL wrap_count7: got %0d expected 7", count_o);
    end
    testsRun++;
    if (fetch_ready_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL full_ready_at7: got %b expected 0", fetch_ready_o);
    end
    // Offered beat with a same-cycle pop must still be refused.
    applyStimulus(mk(8'h50), mk(8'h51), 1'b1);
    decode_ready_i = 1'b1;
    #1;
    testsRun++;
    if (fetch_ready_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL full_ready_with_pop: got %b expected 0", fetch_ready_o);
    end
    tick();
    void'(exp.pop_front());
    testsRun++;
    if (count_o !== 4'd6) begin
      testsFailed++;
      $display("[TB] FAIL full_dropped_push: got %0d expected 6", count_o);
    end
    // Push and pop together at count 6.
    applyStimulus(mk(8'h60), mk(8'h61), 1'b1);
    tick();
    void'(exp.pop_front());
    exp.push_back(mk(8'h60));
    exp.push_back(mk(8'h61));
    applyStimulus('0, '0, 1'b0);
    testsRun++;
    if (count_o !== 4'd7) begin
      testsFailed++;
      $display("[TB] FAIL pushpop_count: got %0d expected 7", count_o);
    end
    while (exp.size() > 0) begin
      testsRun++;
      if (decode_entry_o !== exp[0] || decode_valid_o !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL wrap_drain: got %h expected %h", decode_entry_o, exp[0]);
      end
      tick();
      void'(exp.pop_front());
    end
    testsRun++;
    if (count_o !== 4'd0 || decode_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wrap_empty: got count %0d valid %b expected 0 0", count_o, decode_valid_o);
    end
    decode_ready_i = 1'b0;
  endtask

  // Flush beats a simultaneous push and pop; the pushed beat never shows.
  task automatic test_flush();
    fetch_entry_t junk;
    junk       = mk(8'hEF);
    junk.valid = 1'b0;
    decode_ready_i = 1'b0;
    applyStimulus(mk(8'h70), mk(8'h71), 1'b1);
    tick();
    applyStimulus(mk(8'h72), mk(8'h73), 1'b1);
    tick();
    applyStimulus(mk(8'h74), junk, 1'b1);
    tick();
    testsRun++;
    if (count_o !== 4'd5) begin
      testsFailed++;
      $display("[TB] FAIL flush_precount: got %0d expected 5", count_o);
    end
    flush_i        = 1'b1;
    decode_ready_i = 1'b1;
    applyStimulus(mk(8'h7A), mk(8'h7B), 1'b1);
    #1;
    testsRun++;
    if (decode_entry_o !== mk(8'h70) || decode_valid_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL flush_cycle_head: got %h expected %h", decode_entry_o, mk(8'h70));
    end
    tick();
    flush_i = 1'b0;
    applyStimulus('0, '0, 1'b0);
    testsRun++;
    if (count_o !== 4'd0 || decode_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL flush_cleared: got count %0d valid %b expected 0 0", count_o, decode_valid_o);
    end
    testsRun++;
    if (decode_entry_o !== fetch_entry_t'(0)) begin
      testsFailed++;
      $display("[TB] FAIL flush_entry_zero: got %h expected 0", decode_entry_o);
    end
    decode_ready_i = 1'b0;
    applyStimulus(mk(8'h7C), mk(8'h7D), 1'b1);
    tick();
    applyStimulus('0, '0, 1'b0);
    testsRun++;
    if (decode_entry_o !== mk(8'h7C) || count_o !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL flush_after_push: got %h count %0d expected %h count 2", decode_entry_o, count_o, mk(8'h7C));
    end
    decode_ready_i = 1'b1;
    tick();
    tick();
    decode_ready_i = 1'b0;
    testsRun++;
    if (count_o !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL flush_drained: got %0d expected 0", count_o);
    end
  endtask

  // Exception-tagged entry travels untouched and in order.
  task automatic test_exception();
    fetch_entry_t ex1, nxt;
    ex1          = mk(8'h90);
    ex1.ex.valid = 1'b1;
    ex1.ex.cause = 4'd2;
    ex1.ex.tval  = 32'h0000DEAD;
    nxt          = mk(8'h91);
    decode_ready_i = 1'b0;
    applyStimulus(ex1, nxt, 1'b1);
    tick();
    applyStimulus('0, '0, 1'b0);
    decode_ready_i = 1'b1;
    testsRun++;
    if (decode_entry_o !== ex1) begin
      testsFailed++;
      $display("[TB] FAIL exc_entry: got %h expected %h", decode_entry_o, ex1);
    end
    testsRun++;
    if (decode_entry_o.ex.tval !== 32'h0000DEAD || decode_entry_o.ex.cause !== 4'd2) begin
      testsFailed++;
      $display("[TB] FAIL exc_fields: got %h expected %h", decode_entry_o.ex, ex1.ex);
    end
    tick();
    testsRun++;
    if (decode_entry_o !== nxt) begin
      testsFailed++;
      $display("[TB] FAIL exc_next: got %h expected %h", decode_entry_o, nxt);
    end
    tick();
    decode_ready_i = 1'b0;
    testsRun++;
    if (count_o !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL exc_drained: got %0d expected 0", count_o);
    end
  endtask

`ifdef CONFIG_IFQ_BYPASS_EN
  // Empty queue forwards J in the push cycle; only K is stored.
  task automatic test_bypass();
    fetch_entry_t j, k;
    j = mk(8'hA0);
    k = mk(8'hA1);
    decode_ready_i = 1'b1;
    applyStimulus(j, k, 1'b1);
    #1;
    testsRun++;
    if (decode_valid_o !== 1'b1 || decode_entry_o !== j) begin
      testsFailed++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected %h", decode_entry_o, j);
    end
    tick();
    applyStimulus('0, '0, 1'b0);
    testsRun++;
    if (count_o !== 4'd1 || decode_entry_o !== k) begin
      testsFailed++;
      $display("[TB] FAIL bypass_next: got %h count %0d expected %h count 1", decode_entry_o, count_o, k);
    end
    tick();
    decode_ready_i = 1'b0;
    testsRun++;
    if (count_o !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL bypass_drained: got %0d expected 0", count_o);
    end
  endtask
`endif

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_i          = 1'b1;
    flush_i        = 1'b0;
    decode_ready_i = 1'b0;
    applyStimulus('0, '0, 1'b0);
    test_reset();
`ifndef CONFIG_IFQ_BYPASS_EN
    test_ordering();
`endif
    test_compaction();
    test_full_wrap();
    test_flush();
    test_exception();
`ifdef CONFIG_IFQ_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
